// File: rtl/monost_multi.sv
`default_nettype none
// ============================================================================
// Module   : monost_multi
// Purpose  : Multi-channel retriggerable monostable. Each channel turns an
//            asynchronous trigger into a fixed-length pulse. The pulse is
//            followed by an optional hold-off window and a one-cycle done
//            strobe. The pulse width comes from a shared register that can be
//            reprogrammed at run time.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1         system clock
//   rst_n        in   1         asynchronous active-low reset
//   i_trig       in   CHANNELS  asynchronous trigger inputs, one per channel
//   i_clear      in   1         synchronous abort, all channels to IDLE
//   i_width_we   in   1         load i_width_in into the width register
//   i_width_in   in   CNT_W     new pulse width in cycles (0 acts as 1)
//   o_pulse_out  out  CHANNELS  pulse outputs, active-low when OUT_INV=1
//   o_busy       out  CHANNELS  high while a channel is in ACTIVE or HOLD
//   o_done       out  CHANNELS  one-cycle strobe after a normal pulse end
// ============================================================================
module monost_multi #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 24,
  parameter int WAIT_TIME   = 3500000,
  parameter int HOLDOFF     = 0,
  parameter int RETRIG      = 0,
  parameter int EDGE        = 1,
  parameter int OUT_INV     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] i_trig,
  input  logic                i_clear,
  input  logic                i_width_we,
  input  logic [CNT_W-1:0]    i_width_in,
  output logic [CHANNELS-1:0] o_pulse_out,
  output logic [CHANNELS-1:0] o_busy,
  output logic [CHANNELS-1:0] o_done
);

  localparam logic [CNT_W-1:0] c_wait_time = CNT_W'(WAIT_TIME);
  localparam logic             c_hold_en   = (HOLDOFF > 0);
  localparam logic [CNT_W-1:0] c_hold_m1   = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;
  localparam logic             c_retrig    = (RETRIG != 0);
  localparam logic             c_edge      = (EDGE != 0);
  localparam logic             c_out_inv   = (OUT_INV != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Shared width register and the reload value derived from it.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width <= c_wait_time;
    end else if (i_width_we) begin
      r_width <= i_width_in;
    end
  end

  // A programmed width of zero behaves like one, so the reload floors at 0.
  // The reload value is copied into the channel counter when a pulse starts,
  // so later width writes never disturb a pulse already running.
  assign w_load = (r_width == '0) ? '0 : (r_width - CNT_W'(1));

  // --------------------------------------------------------------------------
  // Per-channel synchroniser, trigger detector and state machine.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_prev;
      logic                   r_ev;
      logic                   w_sync;
      logic                   w_ev;
      state_t                 r_state;
      state_t                 w_state_nx;
      logic [CNT_W-1:0]       r_cnt;
      logic [CNT_W-1:0]       w_cnt_nx;
      logic                   r_done;
      logic                   w_done_nx;

      assign w_sync = r_sync[SYNC_STAGES-1];
      assign w_ev   = c_edge ? (w_sync & ~r_prev) : w_sync;

      // r_prev keeps tracking the synchronised input during clear, so an
      // edge that coincides with clear is consumed rather than deferred.
      // r_ev is a one-cycle pipeline stage on the event; clearing it here is
      // what drops an edge arriving together with clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
          r_prev <= 1'b0;
          r_ev   <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], i_trig[gi]};
          r_prev <= w_sync;
          r_ev   <= i_clear ? 1'b0 : w_ev;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_done  <= 1'b0;
        end else begin
          r_state <= w_state_nx;
          r_cnt   <= w_cnt_nx;
          r_done  <= w_done_nx;
        end
      end

      always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_done_nx  = 1'b0;
        if (i_clear) begin
          // Abort beats both a new event and counter expiry; no done strobe.
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (r_ev) begin
                w_state_nx = ST_ACTIVE;
                w_cnt_nx   = w_load;
              end
            end
            ST_ACTIVE: begin
              if (r_ev && c_retrig) begin
                w_cnt_nx = w_load;
              end else if (r_cnt == '0) begin
                w_done_nx = 1'b1;
                if (c_hold_en) begin
                  w_state_nx = ST_HOLD;
                  w_cnt_nx   = c_hold_m1;
                end else begin
                  w_state_nx = ST_IDLE;
                  w_cnt_nx   = '0;
                end
              end else begin
                w_cnt_nx = r_cnt - CNT_W'(1);
              end
            end
            ST_HOLD: begin
              // Events are deliberately ignored for the whole hold-off window.
              if (r_cnt == '0) begin
                w_state_nx = ST_IDLE;
              end else begin
                w_cnt_nx = r_cnt - CNT_W'(1);
              end
            end
            default: begin
              w_state_nx = ST_IDLE;
              w_cnt_nx   = '0;
            end
          endcase
        end
      end

      // Outputs decode registered state, so they are glitch-free and follow
      // the asynchronous reset without waiting for a clock edge.
      assign o_pulse_out[gi] = (r_state == ST_ACTIVE) ^ c_out_inv;
      assign o_busy[gi]      = (r_state != ST_IDLE);
      assign o_done[gi]      = r_done;
    end
  endgenerate

endmodule
`default_nettype wire
